// File: rtl/npu_result_reader.sv
// npu_result_reader: pops N signed class scores from the NPU output FIFO,
// tracks the running argmax and reports it with a DONE pulse.
module npu_result_reader #(
   parameter int N_CLASSES   = 10,
   parameter int DW          = 8,
   parameter int IDX_W       = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic             CLKEXT,
   input  logic             RST_GLO_N,
   input  logic             START,
   input  logic             EMPTY,
   input  logic [DW-1:0]    D_OUT,
   output logic             RD_EN,
   output logic             BUSY,
   output logic             DONE,
   output logic [IDX_W-1:0] CLASS_OUT,
   output logic [DW-1:0]    MAX_SCORE,
   output logic             ERR_TIMEOUT
);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [IDX_W-1:0] N_L     = IDX_W'(N_CLASSES);
   localparam logic [TW-1:0]    TO_L    = TW'(TIMEOUT_CYC - 1);
   localparam logic [IDX_W-1:0] ERR_IDX = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_DRAIN,
      S_FINISH
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] rd_cnt_q, rd_cnt_d;
   logic [IDX_W-1:0] cap_cnt_q, cap_cnt_d;
   logic             cap_pend_q, cap_pend_d;
   logic [TW-1:0]    tmo_q, tmo_d;
   logic [DW-1:0]    best_score_q, best_score_d;
   logic [IDX_W-1:0] best_idx_q, best_idx_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [IDX_W-1:0] class_q, class_d;
   logic [DW-1:0]    max_q, max_d;
   logic             err_q, err_d;
   logic             abort;

   // Pop only while reading, data present and the job still owes pops.
   assign RD_EN = (state_q == S_READ) && !EMPTY && (rd_cnt_q < N_L);

   assign BUSY        = busy_q;
   assign DONE        = done_q;
   assign CLASS_OUT   = class_q;
   assign MAX_SCORE   = max_q;
   assign ERR_TIMEOUT = err_q;

   // Next-state: pop/capture bookkeeping, argmax update and watchdog.
   always_comb begin
      state_d      = state_q;
      rd_cnt_d     = rd_cnt_q;
      cap_cnt_d    = cap_cnt_q;
      cap_pend_d   = cap_pend_q;
      tmo_d        = tmo_q;
      best_score_d = best_score_q;
      best_idx_d   = best_idx_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      class_d      = class_q;
      max_d        = max_q;
      err_d        = err_q;
      abort        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (START) begin
               state_d    = S_READ;
               rd_cnt_d   = '0;
               cap_cnt_d  = '0;
               cap_pend_d = 1'b0;
               tmo_d      = '0;
               err_d      = 1'b0;
               busy_d     = 1'b1;
            end
         end
         S_READ, S_DRAIN: begin
            cap_pend_d = RD_EN;
            if (RD_EN) begin
               rd_cnt_d = rd_cnt_q + 1'b1;
               tmo_d    = '0;
            end else if (state_q == S_READ && EMPTY) begin
               if (tmo_q == TO_L) abort = 1'b1;
               else tmo_d = tmo_q + 1'b1;
            end
            // Data from last cycle's pop is on D_OUT now; slot = cap_cnt.
            if (cap_pend_q) begin
               if (cap_cnt_q == '0 ||
                   $signed(D_OUT) > $signed(best_score_q)) begin
                  best_score_d = D_OUT;
                  best_idx_d   = cap_cnt_q;
               end
               cap_cnt_d = cap_cnt_q + 1'b1;
            end
            if (abort) begin
               state_d    = S_FINISH;
               cap_pend_d = 1'b0;
               busy_d     = 1'b0;
               done_d     = 1'b1;
               err_d      = 1'b1;
               class_d    = ERR_IDX;
               max_d      = '0;
            end else if (state_q == S_READ && rd_cnt_d == N_L) begin
               state_d = S_DRAIN;
            end else if (state_q == S_DRAIN && cap_cnt_d == N_L) begin
               state_d = S_FINISH;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               class_d = best_idx_d;
               max_d   = best_score_d;
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // State and registered outputs; reset drops everything at once.
   always_ff @(posedge CLKEXT or negedge RST_GLO_N) begin
      if (!RST_GLO_N) begin
         state_q      <= S_IDLE;
         rd_cnt_q     <= '0;
         cap_cnt_q    <= '0;
         cap_pend_q   <= 1'b0;
         tmo_q        <= '0;
         best_score_q <= '0;
         best_idx_q   <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         class_q      <= '0;
         max_q        <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         rd_cnt_q     <= rd_cnt_d;
         cap_cnt_q    <= cap_cnt_d;
         cap_pend_q   <= cap_pend_d;
         tmo_q        <= tmo_d;
         best_score_q <= best_score_d;
         best_idx_q   <= best_idx_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         class_q      <= class_d;
         max_q        <= max_d;
         err_q        <= err_d;
      end
   end

endmodule

// File: tb/tb_npu_result_reader.sv
// tb_npu_result_reader: directed vectors against a FIFO model,
// plus trickle, starvation, reset and START-retrigger sequences.
module tb_npu_result_reader;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       empty;
   logic [7:0] dout;
   logic       rd_en;
   logic       busy;
   logic       done;
   logic [3:0] cls;
   logic [7:0] mx;
   logic       err;

   logic [7:0] mem [0:255];
   logic [7:0] wr_ptr;
   logic [7:0] rd_ptr = 8'd0;
   logic       flush;
   int         done_cnt = 0;
   int         viol = 0;

   int         checks = 0;
   int         errors = 0;

   typedef struct {
      logic [9:0][7:0] s;
      logic [3:0]      cls;
      logic [7:0]      mx;
   } vec_t;
   vec_t tv [6];

   always #5 clk = ~clk;

   npu_result_reader #(
      .N_CLASSES(10), .DW(8), .IDX_W(4), .TIMEOUT_CYC(16)
   ) dut (
      .CLKEXT(clk), .RST_GLO_N(rst_n), .START(start),
      .EMPTY(empty), .D_OUT(dout), .RD_EN(rd_en), .BUSY(busy),
      .DONE(done), .CLASS_OUT(cls), .MAX_SCORE(mx),
      .ERR_TIMEOUT(err)
   );

   assign empty = (wr_ptr == rd_ptr);

   // FIFO read side: data appears the cycle after the pop edge.
   always @(posedge clk) begin
      if (flush) rd_ptr <= wr_ptr;
      else if (rd_en) begin
         dout   <= mem[rd_ptr];
         rd_ptr <= rd_ptr + 8'd1;
      end
   end

   always @(negedge clk) begin
      if (done) done_cnt <= done_cnt + 1;
      if (rd_en && empty) viol <= viol + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [9:0][7:0] pk(
      input int a0, input int a1, input int a2, input int a3,
      input int a4, input int a5, input int a6, input int a7,
      input int a8, input int a9);
      logic [9:0][7:0] r;
      r[0] = 8'(a0); r[1] = 8'(a1); r[2] = 8'(a2); r[3] = 8'(a3);
      r[4] = 8'(a4); r[5] = 8'(a5); r[6] = 8'(a6); r[7] = 8'(a7);
      r[8] = 8'(a8); r[9] = 8'(a9);
      return r;
   endfunction

   task automatic push(input logic [9:0][7:0] s, input int n);
      for (int i = 0; i < n; i++) begin
         mem[wr_ptr] = s[i];
         wr_ptr = wr_ptr + 8'd1;
      end
   endtask

   task automatic start_and_wait(output int lat, output logic b0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      b0 = busy;
      while (!done && lat < 200) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      int         lat;
      int         d0;
      logic       b0;
      logic [7:0] r0;
      logic [7:0] pops;
      logic [9:0][7:0] tr;

      tv[0] = '{pk(3, 9, -5, 9, 0, 1, 2, 7, 4, 8), 4'd1, 8'h09};
      tv[1] = '{pk(-128, -128, -128, -128, -128,
                   -128, -128, -128, -128, -128), 4'd0, 8'h80};
      tv[2] = '{pk(-128, -128, -128, -128, -128,
                   -128, -128, -128, -128, 127), 4'd9, 8'h7F};
      tv[3] = '{pk(127, 1, 0, -1, -2, -3, -4, -5, -6, -128),
                4'd0, 8'h7F};
      tv[4] = '{pk(-10, -20, -30, -40, -50, -1, -60, -70, -1, -128),
                4'd5, 8'hFF};
      tv[5] = '{pk(-1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 4'd1, 8'h00};

      rst_n = 1'b0; start = 1'b0; flush = 1'b0; wr_ptr = 8'd0;
      repeat (2) @(negedge clk);
      chk("rst_rd_en", 32'(rd_en), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_class", 32'(cls), 0);
      chk("rst_max", 32'(mx), 0);
      chk("rst_err", 32'(err), 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         push(tv[i].s, 10);
         r0 = rd_ptr;
         d0 = done_cnt;
         start_and_wait(lat, b0);
         pops = rd_ptr - r0;
         chk($sformatf("v%0d_lat", i), lat, 11);
         chk($sformatf("v%0d_busy0", i), 32'(b0), 1);
         chk($sformatf("v%0d_busy_done", i), 32'(busy), 0);
         chk($sformatf("v%0d_class", i), 32'(cls), 32'(tv[i].cls));
         chk($sformatf("v%0d_max", i), 32'(mx), 32'(tv[i].mx));
         chk($sformatf("v%0d_err", i), 32'(err), 0);
         chk($sformatf("v%0d_pops", i), 32'(pops), 10);
         repeat (2) @(negedge clk);
         chk($sformatf("v%0d_ndone", i), done_cnt - d0, 1);
         chk($sformatf("v%0d_hold", i), 32'(cls), 32'(tv[i].cls));
      end

      // one score every 3 cycles
      tr = pk(-1, -3, 5, 5, -7, 2, 4, 6, 6, -2);
      r0 = rd_ptr;
      fork
         begin
            for (int j = 0; j < 10; j++) begin
               mem[wr_ptr] = tr[j];
               wr_ptr = wr_ptr + 8'd1;
               repeat (3) @(negedge clk);
            end
         end
         start_and_wait(lat, b0);
      join
      pops = rd_ptr - r0;
      chk("trk_done", 32'(lat < 200), 1);
      chk("trk_pops", 32'(pops), 10);
      chk("trk_class", 32'(cls), 7);
      chk("trk_max", 32'(mx), 32'h06);
      chk("trk_err", 32'(err), 0);

      // starvation: 4 scores only
      push(pk(5, -3, 100, 7, 0, 0, 0, 0, 0, 0), 4);
      r0 = rd_ptr;
      start_and_wait(lat, b0);
      pops = rd_ptr - r0;
      chk("tmo_lat", lat, 20);
      chk("tmo_err", 32'(err), 1);
      chk("tmo_class", 32'(cls), 32'hF);
      chk("tmo_max", 32'(mx), 0);
      chk("tmo_pops", 32'(pops), 4);
      repeat (3) @(negedge clk);
      chk("tmo_sticky", 32'(err), 1);
      chk("tmo_rd_en", 32'(rd_en), 0);
      push(tv[0].s, 10);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("tmo_clear", 32'(err), 0);
      lat = 0;
      while (!done && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk("tmo_next_lat", lat, 11);
      chk("tmo_next_class", 32'(cls), 1);
      chk("tmo_next_max", 32'(mx), 32'h09);

      // reset mid-job after 5 pops
      @(negedge clk);
      push(tv[3].s, 10);
      r0 = rd_ptr;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      pops = rd_ptr - r0;
      chk("rst5_pops", 32'(pops), 5);
      chk("rst5_rd_en_pre", 32'(rd_en), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst5_rd_en", 32'(rd_en), 0);
      chk("rst5_busy", 32'(busy), 0);
      chk("rst5_class", 32'(cls), 0);
      chk("rst5_max", 32'(mx), 0);
      d0 = done_cnt;
      flush = 1'b1;
      repeat (3) @(negedge clk);
      flush = 1'b0;
      rst_n = 1'b1;
      chk("rst5_nodone", done_cnt - d0, 0);
      @(negedge clk);
      push(tv[4].s, 10);
      start_and_wait(lat, b0);
      chk("rst5_new_lat", lat, 11);
      chk("rst5_new_class", 32'(cls), 5);
      chk("rst5_new_max", 32'(mx), 32'hFF);

      // START re-pulsed while busy
      repeat (2) @(negedge clk);
      d0 = done_cnt;
      push(tv[2].s, 10);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (!done && lat < 200) begin
         @(negedge clk);
         lat++;
         start = (lat == 3 || lat == 6);
      end
      start = 1'b0;
      chk("rep_lat", lat, 11);
      chk("rep_class", 32'(cls), 9);
      chk("rep_max", 32'(mx), 32'h7F);
      push(tv[0].s, 10);
      @(negedge clk);
      start_and_wait(lat, b0);
      chk("after_lat", lat, 11);
      chk("after_class", 32'(cls), 1);
      // START during the FINISH cycle is dropped
      push(tv[5].s, 10);
      r0 = rd_ptr;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("fin_busy", 32'(busy), 0);
      repeat (2) @(negedge clk);
      pops = rd_ptr - r0;
      chk("fin_pops", 32'(pops), 0);
      chk("rep_ndone", done_cnt - d0, 2);
      start_and_wait(lat, b0);
      chk("fin_next_class", 32'(cls), 1);
      chk("fin_next_max", 32'(mx), 0);

      chk("rd_en_when_empty", viol, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/npu_result_reader.md
Name: npu_result_reader

Overview:
Downstream consumer of npu_top's output FIFO (D_OUT/EMPTY/RD_EN).
- On a START pulse, pops N_CLASSES signed class scores from the FIFO.
- Tracks a running argmax and reports the winning class index and its score with a one-cycle DONE pulse.
- Closes the MNIST classification path: 10 int8 logits in, one digit index out.
- Watchdog aborts the job if the FIFO starves.

Parameters:
N_CLASSES, 10, number of scores popped per job (2..15)
DW, 8, score width, two's-complement signed
IDX_W, 4, class index width; all-ones (4'hF) is reserved as the error index
TIMEOUT_CYC, 1024, consecutive EMPTY cycles tolerated while waiting for data before abort

Ports:
CLKEXT  in  1  system clock, rising edge
RST_GLO_N  in  1  asynchronous active-low reset
START  in  1  single-cycle job request; ignored while BUSY=1
EMPTY  in  1  FIFO empty flag from npu_top
D_OUT  in  DW  FIFO read data; valid in the cycle after a pop edge
RD_EN  out  1  FIFO pop request; combinational from registered state and EMPTY
BUSY  out  1  high from the edge that samples START until the edge that asserts DONE
DONE  out  1  one-cycle pulse when the job completes or aborts
CLASS_OUT  out  IDX_W  argmax index; held until the next DONE
MAX_SCORE  out  DW  score at CLASS_OUT; held until the next DONE
ERR_TIMEOUT  out  1  sticky abort flag; cleared by the next accepted START

Behaviour:
- Reset, asynchronous on RST_GLO_N=0:
  - State goes to IDLE; all counters are cleared.
  - RD_EN=0 immediately, not waiting for a clock edge.
  - BUSY=0, DONE=0, CLASS_OUT=0, MAX_SCORE=0, ERR_TIMEOUT=0.
  - A job in progress is lost; no DONE pulse is produced.
- States: IDLE, READ, DRAIN, FINISH.
- IDLE:
  - START=1 at an edge -> READ.
  - That edge clears rd_cnt, cap_cnt, the timeout counter and ERR_TIMEOUT, and sets BUSY.
- READ:
  - RD_EN = !EMPTY and (rd_cnt < N_CLASSES).
  - Each edge with RD_EN=1 increments rd_cnt and sets cap_pend.
  - When rd_cnt reaches N_CLASSES -> DRAIN.
- Capture, in READ or DRAIN:
  - At an edge with cap_pend=1, D_OUT is sampled and compared, and cap_cnt increments.
  - A pop and a capture at the same edge are legal; this gives one score per cycle when the FIFO is non-empty.
- Argmax rules:
  - The first capture of a job loads best_score and best_idx=0 unconditionally.
  - Later captures replace best only if the signed score is strictly greater than best_score. Ties keep the lowest index.
  - Comparison is DW-bit signed: 8'h80 = -128 is the minimum, 8'h7F = +127 the maximum.
- DRAIN: when cap_cnt reaches N_CLASSES -> FINISH.
- FINISH, one cycle:
  - CLASS_OUT and MAX_SCORE register best_idx and best_score.
  - DONE=1 for this cycle, BUSY=0, next state IDLE.
- Latency: with the FIFO holding all N scores and START sampled at edge k:
  - Pops occur at edges k+1..k+N.
  - Captures occur at edges k+2..k+N+1.
  - FINISH is entered at edge k+N+1, so DONE is high during the cycle after edge k+N+1. For N=10 this is 11 cycles after START.
- Starvation:
  - EMPTY=1 in READ simply stalls pops, with no data loss.
  - The timeout counter increments each READ cycle with EMPTY=1 and no pop, and resets on every pop.
  - When it reaches TIMEOUT_CYC-1 -> FINISH with ERR_TIMEOUT=1, CLASS_OUT=4'hF, MAX_SCORE=0 and a DONE pulse.
  - Partially popped scores stay consumed; RD_EN=0 from the abort onward.
- START while BUSY=1, or in the FINISH cycle, is ignored. START at the edge leaving FINISH, when the state is IDLE, is accepted.
- RD_EN is never asserted when EMPTY=1, in IDLE, or after N pops of a job.

Test Plan:
1. Preload FIFO {3,9,-5,9,0,1,2,7,4,8}, pulse START -> 10 pops on consecutive cycles, DONE 11 cycles after START, CLASS_OUT=1, MAX_SCORE=8'h09, ERR_TIMEOUT=0.
2. All scores 8'h80 (-128) -> CLASS_OUT=0, MAX_SCORE=8'h80. Then a job with 127 in slot 9 and -128 elsewhere -> CLASS_OUT=9, MAX_SCORE=8'h7F.
3. FIFO fed one score every 3 cycles -> RD_EN high only when EMPTY=0, exactly 10 pops, correct argmax, no timeout.
4. Only 4 scores available, TIMEOUT_CYC=16 -> after 16 empty cycles DONE pulses with ERR_TIMEOUT=1 and CLASS_OUT=4'hF. The next START clears ERR_TIMEOUT.
5. RST_GLO_N low after 5 pops -> RD_EN, BUSY and outputs drop to 0 before the next edge, no DONE. After release, a new job on a fresh FIFO gives the correct result.
6. START repulsed while BUSY -> ignored, single DONE. START in the cycle after DONE -> second job accepted and runs normally.
